// File: rtl/fpu16_issue_queue.sv
// fpu16_issue_queue: tagged request FIFO -> combinational FP16 FPU -> tagged response FIFO.
// Latency: 2 edges from request handshake to rspValid (accept, then issue). Sustains 1 op/cycle.
// Backpressure: reqReady drops when the request FIFO is full. Issue stalls when the response FIFO is full and not popping.
//
// Ports:
//   clock, reset      : system clock; synchronous active-high reset
//   req*              : client request channel (valid/ready), {op, A, B, tag}
//   fpuIn1/2, fpuOp   : operands/op driven to the FPU from the request-FIFO head (0 when empty)
//   fpuResult/fpuCond : combinational FPU outputs, sampled on the issue edge
//   rsp*              : client response channel (valid/ready), {result, cond, tag, err}
// Optional feature macro: FPU_ISSUE_MULDIV_TRAP_EN. When it is defined, MUL/DIV heads are not sent to
// the FPU. They complete in order with a qNaN result, cond=0 and rspErr=1.
module fpu16_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CC_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [1:0]       reqOp,
  input  logic [15:0]      reqA,
  input  logic [15:0]      reqB,
  input  logic [TAG_W-1:0] reqTag,
  output logic [15:0]      fpuIn1,
  output logic [15:0]      fpuIn2,
  output logic [1:0]       fpuOp,
  input  logic [15:0]      fpuResult,
  input  logic [CC_W-1:0]  fpuCond,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [15:0]      rspResult,
  output logic [CC_W-1:0]  rspCond,
  output logic [TAG_W-1:0] rspTag,
  output logic             rspErr
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [1:0]       op;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [15:0]      result;
    logic [CC_W-1:0]  cond;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  req_t          req_mem_q [DEPTH];
  req_t          req_mem_d [DEPTH];
  rsp_t          rsp_mem_q [DEPTH];
  rsp_t          rsp_mem_d [DEPTH];
  logic [AW-1:0] req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [AW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CW-1:0] req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;

  logic req_push, req_nonempty, issue, rsp_pop, trap;
  req_t head;
  rsp_t rsp_head, rsp_in;

  // Handshakes, FPU drive and response formation
  always_comb begin
    head         = req_mem_q[req_rd_q];
    rsp_head     = rsp_mem_q[rsp_rd_q];
    req_nonempty = (req_cnt_q != '0);
    // reqReady comes from the registered count only, so a full FIFO stalls one cycle even while issuing.
    reqReady     = (req_cnt_q < FULL);
    rspValid     = (rsp_cnt_q != '0);
    req_push     = reqValid && reqReady;
    rsp_pop      = rspValid && rspReady;
    // A full response FIFO can still take a new entry on the same edge that it pops one.
    issue        = req_nonempty && ((rsp_cnt_q < FULL) || rsp_pop);
`ifdef FPU_ISSUE_MULDIV_TRAP_EN
    trap = head.op[1] && req_nonempty;
`else
    trap = 1'b0;
`endif
    fpuIn1 = '0;
    fpuIn2 = '0;
    fpuOp  = '0;
    if (req_nonempty && !trap) begin
      fpuIn1 = head.a;
      fpuIn2 = head.b;
      fpuOp  = head.op;
    end
    rsp_in.result = trap ? 16'h7E00 : fpuResult;
    rsp_in.cond   = trap ? '0 : fpuCond;
    rsp_in.tag    = head.tag;
    rsp_in.err    = trap;
    rspResult = '0;
    rspCond   = '0;
    rspTag    = '0;
    rspErr    = 1'b0;
    if (rspValid) begin
      rspResult = rsp_head.result;
      rspCond   = rsp_head.cond;
      rspTag    = rsp_head.tag;
      rspErr    = rsp_head.err;
    end
  end

  // Next-state for both FIFOs
  always_comb begin
    req_mem_d = req_mem_q;
    rsp_mem_d = rsp_mem_q;
    req_wr_d  = req_wr_q;
    req_rd_d  = req_rd_q;
    rsp_wr_d  = rsp_wr_q;
    rsp_rd_d  = rsp_rd_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    if (req_push) begin
      req_mem_d[req_wr_q] = '{op: reqOp, a: reqA, b: reqB, tag: reqTag};
      req_wr_d = req_wr_q + AW'(1);
    end
    if (issue) begin
      req_rd_d = req_rd_q + AW'(1);
      rsp_mem_d[rsp_wr_q] = rsp_in;
      rsp_wr_d = rsp_wr_q + AW'(1);
    end
    if (rsp_pop) begin
      rsp_rd_d = rsp_rd_q + AW'(1);
    end
    case ({req_push, issue})
      2'b10:   req_cnt_d = req_cnt_q + CW'(1);
      2'b01:   req_cnt_d = req_cnt_q - CW'(1);
      default: req_cnt_d = req_cnt_q;
    endcase
    case ({issue, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + CW'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - CW'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        req_mem_q[i] <= '0;
        rsp_mem_q[i] <= '0;
      end
      req_wr_q  <= '0;
      req_rd_q  <= '0;
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      req_mem_q <= req_mem_d;
      rsp_mem_q <= rsp_mem_d;
      req_wr_q  <= req_wr_d;
      req_rd_q  <= req_rd_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_rd_q  <= rsp_rd_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end
endmodule

// File: tb/tb_fpu16_issue_queue.sv
// Directed bench for fpu16_issue_queue with a small FP16 FPU stub.
// Inputs are driven and outputs sampled on the falling edge.
module tb_fpu16_issue_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid, reqReady;
  logic [1:0]  reqOp;
  logic [15:0] reqA, reqB;
  logic [3:0]  reqTag;
  logic [15:0] fpuIn1, fpuIn2, fpuResult;
  logic [1:0]  fpuOp;
  logic [3:0]  fpuCond;
  logic        rspValid, rspReady, rspErr;
  logic [15:0] rspResult;
  logic [3:0]  rspCond, rspTag;

  int tests = 0;
  int fails = 0;
  int idx, got, first, last, stale;
  bit acc;

  logic [1:0]  b2b_op  [3] = '{2'd0, 2'd1, 2'd0};
  logic [3:0]  b2b_tag [3] = '{4'd1, 4'd2, 4'd3};
  logic [15:0] b2b_res [3] = '{16'h4200, 16'hBC00, 16'h4200};
  logic [3:0]  b2b_cc  [3] = '{4'h4, 4'hB, 4'h4};

  always #5 clock = ~clock;

  // FPU stub: exact FP16 answers for the directed operand pairs, simple integer sum otherwise.
  function automatic logic [15:0] fpu_stub(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 2'd0 && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    if (op == 2'd1 && a == 16'h3C00 && b == 16'h4000) return 16'hBC00;
    if (op == 2'd2 && a == 16'h4000 && b == 16'h4000) return 16'h4400;
    return a + b + {14'd0, op};
  endfunction

  assign fpuResult = fpu_stub(fpuOp, fpuIn1, fpuIn2);
  assign fpuCond   = fpuResult[15:12];

  fpu16_issue_queue #(.DEPTH(4), .TAG_W(4), .CC_W(4)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqA(reqA), .reqB(reqB), .reqTag(reqTag),
    .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuOp(fpuOp), .fpuResult(fpuResult), .fpuCond(fpuCond),
    .rspValid(rspValid), .rspReady(rspReady), .rspResult(rspResult), .rspCond(rspCond),
    .rspTag(rspTag), .rspErr(rspErr)
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string nm, input logic [15:0] res, input logic [3:0] cc,
                         input logic [3:0] tg, input logic er);
    chk({nm, "_vld"}, rspValid, 1);
    chk({nm, "_res"}, rspResult, res);
    chk({nm, "_cond"}, rspCond, cc);
    chk({nm, "_tag"}, rspTag, tg);
    chk({nm, "_err"}, rspErr, er);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] tg);
    reqValid = v; reqOp = op; reqA = a; reqB = b; reqTag = tg;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rspReady = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    chk("rst_reqReady", reqReady, 1);
    chk("rst_rspValid", rspValid, 0);
    chk("rst_fpuIn1", fpuIn1, 0);
    chk("rst_fpuIn2", fpuIn2, 0);
    chk("rst_fpuOp", fpuOp, 0);
    chk("rst_rspResult", rspResult, 0);
    chk("rst_rspTag", rspTag, 0);
    chk("rst_rspErr", rspErr, 0);

    // Single ADD 1.0 + 2.0 = 3.0
    rspReady = 1'b1;
    drive(1'b1, 2'd0, 16'h3C00, 16'h4000, 4'd3);
    @(negedge clock);
    drive(1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
    chk("add_fpuIn1", fpuIn1, 16'h3C00);
    chk("add_fpuIn2", fpuIn2, 16'h4000);
    chk("add_fpuOp", fpuOp, 0);
    chk("add_rspValid_early", rspValid, 0);
    @(negedge clock);
    chk_rsp("add", 16'h4200, 4'h4, 4'd3, 1'b0);
    @(negedge clock);
    chk("add_drained", rspValid, 0);
    chk("add_fpu_idle", fpuIn1, 0);

    // Back-to-back ADD/SUB/ADD
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 10; c++) begin
      if (rspValid) begin
        if (got < 3) chk_rsp("b2b", b2b_res[got], b2b_cc[got], b2b_tag[got], 1'b0);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 3) drive(1'b1, b2b_op[c], 16'h3C00, 16'h4000, b2b_tag[c]);
      else       drive(1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
      @(negedge clock);
    end
    chk("b2b_count", got, 3);
    chk("b2b_first", first, 2);
    chk("b2b_consecutive", last - first, 2);

    // Backpressure: 9 requests with no response consumption
    rspReady = 1'b0; idx = 0; acc = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (acc) idx++;
      drive(idx < 9, 2'd0, 16'h1000 + 16'(idx), 16'h0200 + 16'(idx), 4'(idx));
      acc = reqValid && reqReady;
    end
    chk("bp_accepted", idx, 8);
    chk("bp_reqReady", reqReady, 0);
    chk("bp_rspValid", rspValid, 1);
    chk("bp_head_tag", rspTag, 0);
    rspReady = 1'b1; got = 0;
    for (int c = 0; c < 30; c++) begin
      if (rspValid) begin
        if (got < 9) chk_rsp("bp", 16'h1200 + 16'(2 * got), 4'h1, 4'(got), 1'b0);
        got++;
      end
      drive(idx < 9, 2'd0, 16'h1000 + 16'(idx), 16'h0200 + 16'(idx), 4'(idx));
      acc = reqValid && reqReady;
      @(negedge clock);
      if (acc) idx++;
    end
    drive(1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
    chk("bp_rsp_count", got, 9);
    chk("bp_last_accepted", idx, 9);

    // Reset with requests queued and responses pending
    rspReady = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 2'd0, 16'h2000 + 16'(i), 16'h0100, 4'(8 + i));
      @(negedge clock);
    end
    drive(1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
    @(negedge clock);
    chk("mid_pre_rspValid", rspValid, 1);
    chk("mid_pre_fpuIn1", fpuIn1, 16'h2004);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rspValid", rspValid, 0);
    chk("mid_reqReady", reqReady, 1);
    chk("mid_fpuIn1", fpuIn1, 0);
    chk("mid_rspTag", rspTag, 0);
    rspReady = 1'b1; stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (rspValid) stale++;
    end
    chk("mid_no_stale", stale, 0);

    // Response held stable under backpressure
    rspReady = 1'b0;
    drive(1'b1, 2'd1, 16'h3C00, 16'h4000, 4'd5);
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h3C00, 16'h4000, 4'd6);
    @(negedge clock);
    drive(1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
    for (int c = 0; c < 5; c++) begin
      chk_rsp("hold", 16'hBC00, 4'hB, 4'd5, 1'b0);
      @(negedge clock);
    end
    rspReady = 1'b1;
    chk_rsp("hold_release", 16'hBC00, 4'hB, 4'd5, 1'b0);
    @(negedge clock);
    chk_rsp("hold_next", 16'h4200, 4'h4, 4'd6, 1'b0);
    @(negedge clock);
    chk("hold_drained", rspValid, 0);

    // MUL 2.0 * 2.0
    drive(1'b1, 2'd2, 16'h4000, 16'h4000, 4'd7);
    @(negedge clock);
    drive(1'b0, 2'd0, 16'h0, 16'h0, 4'd0);
`ifdef FPU_ISSUE_MULDIV_TRAP_EN
    chk("mul_fpuOp", fpuOp, 0);
    chk("mul_fpuIn1", fpuIn1, 0);
    @(negedge clock);
    chk_rsp("mul_trap", 16'h7E00, 4'h0, 4'd7, 1'b1);
`else
    chk("mul_fpuOp", fpuOp, 2);
    chk("mul_fpuIn1", fpuIn1, 16'h4000);
    @(negedge clock);
    chk_rsp("mul", 16'h4400, 4'h4, 4'd7, 1'b0);
`endif
    @(negedge clock);
    chk("mul_drained", rspValid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
